// File: rtl/ad.sv
`default_nettype none
// ============================================================================
// Module   : ad
// Purpose  : Front end for two parallel ADCs sharing one sample clock.
//            - Divides clk down to a programmable ADC sample clock.
//            - Captures both ADC channels once per sample-clock period,
//              on the clk cycle where the sample clock falls (mid-period).
//            - Resynchronises the asynchronous active-low line/frame syncs.
// Ports    : clk            system clock, all logic on rising edge
//            reset_n        asynchronous active-low reset
//            ext_hsync_i    external line sync (async, active low)
//            ext_vsync_i    external frame sync (async, active low)
//            sample_clock_i divider select N; period = 2*(N+1) clk cycles
//            ad1_in/ad2_in  ADC parallel data
//            ad1_clk/ad2_clk registered ADC sample clocks (identical)
//            ad_ch1/ad_ch2  captured samples
//            hs_o/vs_o      synchronised syncs, active low
// Options  : AD_TWOS_COMP_EN - when defined, the captured MSB is inverted
//            (offset binary to two's complement).
// Revision : 1.0 - initial release
// ============================================================================
module ad #(
  parameter int DW       = 12,
  parameter int DIVW     = 5,
  parameter int SYNC_STG = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            ext_hsync_i,
  input  logic            ext_vsync_i,
  input  logic [DIVW-1:0] sample_clock_i,
  input  logic [DW-1:0]   ad1_in,
  output logic            ad1_clk,
  input  logic [DW-1:0]   ad2_in,
  output logic            ad2_clk,
  output logic [DW-1:0]   ad_ch1,
  output logic [DW-1:0]   ad_ch2,
  output logic            hs_o,
  output logic            vs_o
);

`ifdef AD_TWOS_COMP_EN
  localparam logic [DW-1:0] C_MSB_FLIP = {1'b1, {(DW-1){1'b0}}};
`else
  localparam logic [DW-1:0] C_MSB_FLIP = '0;
`endif

  logic [DIVW-1:0]     r_cnt;
  logic                r_adc_clk;
  logic                w_wrap;
  logic                w_strobe;
  logic [SYNC_STG-1:0] r_hs_sync;
  logic [SYNC_STG-1:0] r_vs_sync;

  // Greater-or-equal (not equal) so that lowering N below the current count
  // wraps on the very next cycle instead of running through the full range.
  assign w_wrap   = (r_cnt >= sample_clock_i);
  // Sample on the falling toggle: ADC data is stable mid-period.
  assign w_strobe = w_wrap & r_adc_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt     <= '0;
      r_adc_clk <= 1'b0;
    end else if (w_wrap) begin
      r_cnt     <= '0;
      r_adc_clk <= ~r_adc_clk;
    end else begin
      r_cnt     <= r_cnt + DIVW'(1);
    end
  end

  assign ad1_clk = r_adc_clk;
  assign ad2_clk = r_adc_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ad_ch1 <= '0;
      ad_ch2 <= '0;
    end else if (w_strobe) begin
      ad_ch1 <= ad1_in ^ C_MSB_FLIP;
      ad_ch2 <= ad2_in ^ C_MSB_FLIP;
    end
  end

  // Syncs idle high, so the chains reset to 1 to avoid a false pulse
  // when reset is released.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hs_sync <= '1;
      r_vs_sync <= '1;
      hs_o      <= 1'b1;
      vs_o      <= 1'b1;
    end else begin
      r_hs_sync <= {r_hs_sync[SYNC_STG-2:0], ext_hsync_i};
      r_vs_sync <= {r_vs_sync[SYNC_STG-2:0], ext_vsync_i};
      hs_o      <= r_hs_sync[SYNC_STG-1];
      vs_o      <= r_vs_sync[SYNC_STG-1];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ad.sv
`default_nettype none
// ============================================================================
// Module   : tb_ad
// Purpose  : Directed self-checking bench for ad (reset, capture, syncs,
//            divider reprogramming, reset during operation).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ad;

  logic        clk;
  logic        reset_n;
  logic        ext_hsync_i;
  logic        ext_vsync_i;
  logic [4:0]  sample_clock_i;
  logic [11:0] ad1_in;
  logic [11:0] ad2_in;
  logic        ad1_clk;
  logic        ad2_clk;
  logic [11:0] ad_ch1;
  logic [11:0] ad_ch2;
  logic        hs_o;
  logic        vs_o;

  int n_checks = 0;
  int n_fail   = 0;

  ad dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .ext_hsync_i    (ext_hsync_i),
    .ext_vsync_i    (ext_vsync_i),
    .sample_clock_i (sample_clock_i),
    .ad1_in         (ad1_in),
    .ad1_clk        (ad1_clk),
    .ad2_in         (ad2_in),
    .ad2_clk        (ad2_clk),
    .ad_ch1         (ad_ch1),
    .ad_ch2         (ad_ch2),
    .hs_o           (hs_o),
    .vs_o           (vs_o)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;   // 50 MHz

  function automatic logic [11:0] exp_code(input logic [11:0] v);
`ifdef AD_TWOS_COMP_EN
    return v ^ 12'h800;
`else
    return v;
`endif
  endfunction

  // Reset held 100 ns while inputs are busy: everything stays at reset values.
  task automatic test_reset();
    reset_n        = 1'b0;
    sample_clock_i = 5'd0;
    ad1_in         = 12'hABC;
    ad2_in         = 12'h555;
    ext_hsync_i    = 1'b0;
    ext_vsync_i    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if ({ad1_clk, ad2_clk, ad_ch1, ad_ch2, hs_o, vs_o} !== {2'b00, 24'h0, 2'b11}) begin
        n_fail++;
        $display("FAIL reset_hold[%0d]: got clk=%b/%b ch=%h/%h hs=%b vs=%b, want 0/0 000/000 1 1",
                 i, ad1_clk, ad2_clk, ad_ch1, ad_ch2, hs_o, vs_o);
      end
    end
    ext_hsync_i = 1'b1;
    ext_vsync_i = 1'b1;
  endtask

  // N=0: sample clock toggles every clk (40 ns period), first capture 2 clk after release.
  task automatic test_capture_n0();
    logic exp_clk;
    ad1_in = 12'h0EF;
    ad2_in = 12'h321;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_clk = (i % 2 == 1);
      n_checks++;
      if (ad1_clk !== exp_clk || ad2_clk !== exp_clk) begin
        n_fail++;
        $display("FAIL n0_clk[%0d]: got ad1_clk=%b ad2_clk=%b, want %b", i, ad1_clk, ad2_clk, exp_clk);
      end
      if (i == 1) begin
        n_checks++;
        if (ad_ch1 !== 12'h000) begin
          n_fail++;
          $display("FAIL n0_early_capture: got ad_ch1=%h, want 000", ad_ch1);
        end
      end
      if (i == 2) begin
        n_checks++;
        if (ad_ch1 !== exp_code(12'h0EF) || ad_ch2 !== exp_code(12'h321)) begin
          n_fail++;
          $display("FAIL n0_first_capture: got ch1=%h ch2=%h, want %h %h",
                   ad_ch1, ad_ch2, exp_code(12'h0EF), exp_code(12'h321));
        end
      end
    end
  endtask

  // vsync low for 35 clk: vs_o falls 3 clk later and stays low exactly 35 clk.
  task automatic test_vsync();
    int first_low = -1;
    int lows      = 0;
    int hs_bad    = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1 ext_vsync_i = (c < 35) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (vs_o === 1'b0) begin
        lows++;
        if (first_low < 0) first_low = c;
      end
      if (hs_o !== 1'b1) hs_bad++;
    end
    n_checks++;
    if (first_low != 3) begin
      n_fail++;
      $display("FAIL vsync_latency: got %0d clk, want 3", first_low);
    end
    n_checks++;
    if (lows != 35) begin
      n_fail++;
      $display("FAIL vsync_width: got %0d clk, want 35", lows);
    end
    n_checks++;
    if (hs_bad != 0 || vs_o !== 1'b1) begin
      n_fail++;
      $display("FAIL vsync_isolation: got hs_o low %0d times, vs_o end=%b, want 0 and 1", hs_bad, vs_o);
    end
  endtask

  // 12 lines: hsync low 35 clk, high 45 clk, ad1_in steps by one per line.
  task automatic test_hsync_lines();
    int   pulses = 0;
    logic prev_hs = 1'b1;
    for (int l = 0; l < 12; l++) begin
      int lows = 0;
      for (int c = 0; c < 80; c++) begin
        @(posedge clk);
        #1;
        ext_hsync_i = (c < 35) ? 1'b0 : 1'b1;
        if (c == 0) ad1_in = 12'h0F0 + 12'(l);
        @(negedge clk);
        if (hs_o === 1'b0) lows++;
        if (prev_hs === 1'b1 && hs_o === 1'b0) pulses++;
        prev_hs = hs_o;
      end
      n_checks++;
      if (lows != 35) begin
        n_fail++;
        $display("FAIL hs_width[line %0d]: got %0d clk, want 35", l, lows);
      end
      n_checks++;
      if (ad_ch1 !== exp_code(12'h0F0 + 12'(l))) begin
        n_fail++;
        $display("FAIL line_capture[line %0d]: got %h, want %h", l, ad_ch1, exp_code(12'h0F0 + 12'(l)));
      end
    end
    n_checks++;
    if (pulses != 12) begin
      n_fail++;
      $display("FAIL hs_pulse_count: got %0d, want 12", pulses);
    end
  endtask

  // N=4 gives a 10 clk period; dropping N to 1 while cnt=3 wraps on the next
  // cycle, after which the period is 4 clk.
  task automatic test_divider();
    logic exp_clk;
    @(posedge clk);
    #1 reset_n = 1'b0;
    sample_clock_i = 5'd4;
    @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 31; i++) begin
      @(posedge clk);
      if (i == 23) #1 sample_clock_i = 5'd1;
      @(negedge clk);
      if (i < 24) exp_clk = ((i / 5) % 2 == 1);
      else        exp_clk = (((i - 24) / 2) % 2 == 0);
      n_checks++;
      if (ad1_clk !== exp_clk) begin
        n_fail++;
        $display("FAIL div_wave[%0d]: got ad1_clk=%b, want %b", i, ad1_clk, exp_clk);
      end
    end
  endtask

  // Reset asserted mid-line: outputs return to reset values without a clock
  // edge; after release capture resumes after 2*(N+1) clk and syncs restart.
  task automatic test_reset_mid();
    logic [11:0] exp_ch;
    logic        exp_hs;
    @(posedge clk);
    #1 reset_n = 1'b0;
    sample_clock_i = 5'd2;
    ad1_in         = 12'h456;
    ad2_in         = 12'h0AA;
    @(posedge clk);
    #1 reset_n = 1'b1;
    ext_hsync_i = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
    n_checks++;
    if (ad_ch1 !== exp_code(12'h456) || hs_o !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_precondition: got ch1=%h hs=%b, want %h 0", ad_ch1, hs_o, exp_code(12'h456));
    end
    @(posedge clk);
    #5 reset_n = 1'b0;
    #1;
    n_checks++;
    if ({ad1_clk, ad2_clk, ad_ch1, ad_ch2, hs_o, vs_o} !== {2'b00, 24'h0, 2'b11}) begin
      n_fail++;
      $display("FAIL async_reset: got clk=%b/%b ch=%h/%h hs=%b vs=%b, want 0/0 000/000 1 1",
               ad1_clk, ad2_clk, ad_ch1, ad_ch2, hs_o, vs_o);
    end
    ad1_in = 12'h789;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      @(negedge clk);
      exp_ch = (i >= 6) ? exp_code(12'h789) : 12'h000;
      exp_hs = (i >= 3) ? 1'b0 : 1'b1;
      n_checks++;
      if (ad_ch1 !== exp_ch) begin
        n_fail++;
        $display("FAIL restart_capture[%0d]: got %h, want %h", i, ad_ch1, exp_ch);
      end
      n_checks++;
      if (hs_o !== exp_hs) begin
        n_fail++;
        $display("FAIL restart_hsync[%0d]: got %b, want %b", i, hs_o, exp_hs);
      end
    end
    ext_hsync_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_capture_n0();
    test_vsync();
    test_hsync_lines();
    test_divider();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
